// File: rtl/mac_accum.sv
// Sequential dot-product accumulator: sums LEN Q(WIDTH-FRAC).FRAC products per result.
// Define SATURATE_EN to clamp each add on overflow; default wraps modulo 2^WIDTH.
module mac_accum #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int CW = $clog2(LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    if (LEN < 1 || FRAC >= WIDTH) begin : g_bad_cfg
        $error("mac_accum: need LEN >= 1 and FRAC < WIDTH");
    end

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_sum;
    logic             w_take;

    // First beat of a result starts from zero rather than the stale accumulator
    assign w_base = (r_cnt == '0) ? '0 : r_acc;

`ifdef SATURATE_EN
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] w_ext;
    logic           w_ovf;

    assign w_ext = {w_base[WIDTH-1], w_base} + {i_data[WIDTH-1], i_data};
    assign w_ovf = w_ext[WIDTH] ^ w_ext[WIDTH-1];
    assign w_sum = !w_ovf ? w_ext[WIDTH-1:0] : (w_ext[WIDTH] ? MINV : MAXV);
`else
    assign w_sum = w_base + i_data;
`endif

    assign o_ready = (r_state == ST_ACC);
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign w_take  = i_valid & o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACC;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_state <= ST_ACC;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_ACC: begin
                    if (w_take) begin
                        if (r_cnt == LAST) begin
                            r_data  <= w_sum;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                            r_valid <= 1'b1;
                            r_state <= ST_HOLD;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_ACC;
                    end
                end
                default: begin
                    r_state <= ST_ACC;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: vector table, corner sequences, random run vs arithmetic model.
// Honours SATURATE_EN the same way as the design.
module tb_mac_accum;

    localparam int W = 32;

`ifdef SATURATE_EN
    localparam logic [31:0] SAT_P = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_N = 32'h8000_0000;
`else
    localparam logic [31:0] SAT_P = 32'hFC00_0000;
    localparam logic [31:0] SAT_N = 32'h0000_0000;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0, v = 1'b0, rdy = 1'b1;
    logic [W-1:0]  d = '0;
    logic          o_rdy, o_v;
    logic [W-1:0]  o_d;
    logic          clr1 = 1'b0, v1 = 1'b0, rdy1 = 1'b1;
    logic [W-1:0]  d1 = '0;
    logic          o_rdy1, o_v1;
    logic [W-1:0]  o_d1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mac_accum #(.WIDTH(32), .FRAC(24), .LEN(4)) dut (
        .clk(clk), .rst(rst), .i_clear(clr), .i_valid(v), .o_ready(o_rdy),
        .i_data(d), .o_valid(o_v), .i_ready(rdy), .o_data(o_d)
    );

    mac_accum #(.WIDTH(32), .FRAC(24), .LEN(1)) dut1 (
        .clk(clk), .rst(rst), .i_clear(clr1), .i_valid(v1), .o_ready(o_rdy1),
        .i_data(d1), .o_valid(o_v1), .i_ready(rdy1), .o_data(o_d1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       nm;
        logic        clr, v, r;
        logic [31:0] d;
        logic        ev, er;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic void pv(string nm, logic c, logic vv, logic r, logic [31:0] dd,
                               logic ev, logic er, logic [31:0] ed);
        vec_t x;
        x.nm = nm; x.clr = c; x.v = vv; x.r = r; x.d = dd;
        x.ev = ev; x.er = er; x.ed = ed;
        tbl.push_back(x);
    endfunction

    // Reference: per-add arithmetic on true integers, clamped or wrapped
    localparam longint MAXL = 64'sd2147483647;
    localparam longint MINL = -64'sd2147483648;

    function automatic logic [31:0] madd(logic [31:0] a, logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef SATURATE_EN
        if (s > MAXL) s = MAXL;
        else if (s < MINL) s = MINL;
`endif
        return s[31:0];
    endfunction

    logic [31:0] m_sum[2], m_out[2];
    int          m_n[2];
    bit          m_hold[2];
    int          m_len[2] = '{4, 1};

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_sum[k] = '0; m_out[k] = '0; m_n[k] = 0; m_hold[k] = 0;
        end
    endfunction

    function automatic void m_step(int k, logic c, logic vv, logic r, logic [31:0] dd);
        if (c) begin
            m_sum[k] = '0; m_n[k] = 0; m_hold[k] = 0;
        end else if (m_hold[k]) begin
            if (r) m_hold[k] = 0;
        end else if (vv) begin
            m_sum[k] = madd(m_sum[k], dd);
            m_n[k]++;
            if (m_n[k] == m_len[k]) begin
                m_out[k] = m_sum[k];
                m_hold[k] = 1;
                m_n[k] = 0;
                m_sum[k] = '0;
            end
        end
    endfunction

    initial begin
        // basic sum 2.75, then backpressure with i_valid held high
        pv("t1b0", 0, 1, 1, 32'h0100_0000, 0, 1, 32'h0);
        pv("t1b1", 0, 1, 1, 32'h0200_0000, 0, 1, 32'h0);
        pv("t1b2", 0, 1, 1, 32'hFF80_0000, 0, 1, 32'h0);
        pv("t1b3", 0, 1, 1, 32'h0040_0000, 1, 0, 32'h02C0_0000);
        pv("t2h0", 0, 1, 0, 32'h1234_5678, 1, 0, 32'h02C0_0000);
        pv("t2h1", 0, 1, 0, 32'h1234_5678, 1, 0, 32'h02C0_0000);
        pv("t2h2", 0, 1, 0, 32'h1234_5678, 1, 0, 32'h02C0_0000);
        pv("t2rl", 0, 0, 1, 32'h0,         0, 1, 32'h02C0_0000);
        pv("t2c0", 0, 1, 1, 32'h0010_0000, 0, 1, 32'h02C0_0000);
        pv("t2c1", 0, 1, 1, 32'h0010_0000, 0, 1, 32'h02C0_0000);
        pv("t2c2", 0, 1, 1, 32'h0010_0000, 0, 1, 32'h02C0_0000);
        pv("t2c3", 0, 1, 1, 32'h0010_0000, 1, 0, 32'h0040_0000);
        // beat presented during the bubble must be ignored
        pv("bub",  0, 1, 1, 32'h7700_0000, 0, 1, 32'h0040_0000);
        pv("bb0",  0, 1, 1, 32'h0100_0000, 0, 1, 32'h0040_0000);
        pv("bb1",  0, 1, 1, 32'h0100_0000, 0, 1, 32'h0040_0000);
        pv("bb2",  0, 1, 1, 32'h0100_0000, 0, 1, 32'h0040_0000);
        pv("bb3",  0, 1, 1, 32'h0100_0000, 1, 0, 32'h0400_0000);
        pv("bbr",  0, 0, 1, 32'h0,         0, 1, 32'h0400_0000);
        // overflow
        pv("sp0",  0, 1, 1, 32'h7F00_0000, 0, 1, 32'h0400_0000);
        pv("sp1",  0, 1, 1, 32'h7F00_0000, 0, 1, 32'h0400_0000);
        pv("sp2",  0, 1, 1, 32'h7F00_0000, 0, 1, 32'h0400_0000);
        pv("sp3",  0, 1, 1, 32'h7F00_0000, 1, 0, SAT_P);
        pv("spr",  0, 0, 1, 32'h0,         0, 1, SAT_P);
        pv("sn0",  0, 1, 1, 32'h8000_0000, 0, 1, SAT_P);
        pv("sn1",  0, 1, 1, 32'h8000_0000, 0, 1, SAT_P);
        pv("sn2",  0, 1, 1, 32'h8000_0000, 0, 1, SAT_P);
        pv("sn3",  0, 1, 1, 32'h8000_0000, 1, 0, SAT_N);
        pv("snr",  0, 0, 1, 32'h0,         0, 1, SAT_N);
        // clear mid-sum drops partial sum and its own beat
        pv("c0",   0, 1, 1, 32'h0100_0000, 0, 1, SAT_N);
        pv("c1",   0, 1, 1, 32'h0100_0000, 0, 1, SAT_N);
        pv("clr",  1, 1, 1, 32'h0100_0000, 0, 1, SAT_N);
        pv("c2",   0, 1, 1, 32'h0100_0000, 0, 1, SAT_N);
        pv("c3",   0, 1, 1, 32'h0100_0000, 0, 1, SAT_N);
        pv("c4",   0, 1, 1, 32'h0100_0000, 0, 1, SAT_N);
        pv("c5",   0, 1, 1, 32'h0100_0000, 1, 0, 32'h0400_0000);
        // clear during HOLD discards result but keeps o_data
        pv("chld", 1, 0, 0, 32'h0,         0, 1, 32'h0400_0000);
        pv("cidl", 0, 0, 1, 32'h0,         0, 1, 32'h0400_0000);

        #12;
        rst = 1'b0;
        #1;
        chk("rst_v", {31'b0, o_v}, 32'h0);
        chk("rst_r", {31'b0, o_rdy}, 32'h1);
        chk("rst_d", o_d, 32'h0);
        chk("rst1_r", {31'b0, o_rdy1}, 32'h1);
        @(negedge clk);

        foreach (tbl[i]) begin
            clr = tbl[i].clr; v = tbl[i].v; rdy = tbl[i].r; d = tbl[i].d;
            tick();
            chk({tbl[i].nm, ".v"}, {31'b0, o_v}, {31'b0, tbl[i].ev});
            chk({tbl[i].nm, ".r"}, {31'b0, o_rdy}, {31'b0, tbl[i].er});
            chk({tbl[i].nm, ".d"}, o_d, tbl[i].ed);
        end
        clr = 0; v = 0; rdy = 1;

        // async reset mid-cycle after 3 beats
        for (int i = 0; i < 3; i++) begin
            v = 1; d = 32'h0080_0000;
            tick();
        end
        v = 0;
        #1 rst = 1'b1;
        #1;
        chk("arst_v", {31'b0, o_v}, 32'h0);
        chk("arst_d", o_d, 32'h0);
        chk("arst_r", {31'b0, o_rdy}, 32'h1);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 1; d = 32'h0080_0000;
            tick();
            chk("post_v", {31'b0, o_v}, (i == 3) ? 32'h1 : 32'h0);
        end
        chk("post_d", o_d, 32'h0200_0000);
        v = 0;
        tick();

        // LEN=1 instance
        v1 = 1; d1 = 32'hFFF0_0000; rdy1 = 1;
        tick();
        chk("l1_v", {31'b0, o_v1}, 32'h1);
        chk("l1_d", o_d1, 32'hFFF0_0000);
        chk("l1_r", {31'b0, o_rdy1}, 32'h0);
        v1 = 0;
        tick();
        chk("l1_v2", {31'b0, o_v1}, 32'h0);
        chk("l1_r2", {31'b0, o_rdy1}, 32'h1);

        // random run against model, both instances
        rst = 1'b1;
        #2 rst = 1'b0;
        m_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] rd;
            rd = $urandom;
            if ($urandom_range(0, 3) != 0) rd = rd >>> 6;
            if (rd[31]) rd = rd | 32'hFC00_0000;
            clr = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            d = rd;
            clr1 = clr; v1 = v; rdy1 = rdy; d1 = rd ^ 32'h0000_1234;
            @(posedge clk);
            m_step(0, clr, v, rdy, d);
            m_step(1, clr1, v1, rdy1, d1);
            #1;
            chk("rnd_v", {31'b0, o_v}, {31'b0, m_hold[0]});
            chk("rnd_r", {31'b0, o_rdy}, {31'b0, !m_hold[0]});
            chk("rnd_d", o_d, m_out[0]);
            chk("rnd1_v", {31'b0, o_v1}, {31'b0, m_hold[1]});
            chk("rnd1_d", o_d1, m_out[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
